// File: rtl/strobe_stream_pkg.sv
// strobe_stream_pkg: shared widths, FIFO status encoding and level-width helper.
package strobe_stream_pkg;
    localparam int OVF_CNT_W = 16;

    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} fifo_status_e;

    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/strobe_stream_ram.sv
// strobe_stream_ram: DEPTH x DW register array, synchronous write, asynchronous read.
module strobe_stream_ram #(
    parameter int DW    = 16,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic signed [DW-1:0] wdata,
    input  logic [AW-1:0]        raddr,
    output logic signed [DW-1:0] rdata
);
    logic signed [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/strobe_stream_reader.sv
// strobe_stream_reader: strobe-qualified sample capture into a FWFT FIFO with sticky overflow.
// Define STROBE_STREAM_OVF_CNT_EN to add the saturating ovf_cnt drop counter.
module strobe_stream_reader
    import strobe_stream_pkg::*;
#(
    parameter int DW    = 16,
    parameter int DEPTH = 4,
    parameter int LW    = lvl_w(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] s_data,
    input  logic                 s_val,
    input  logic                 s_en,
    output logic signed [DW-1:0] m_data,
    output logic                 m_val,
    input  logic                 m_rdy,
    output logic [LW-1:0]        level,
    output logic                 ovf,
    input  logic                 ovf_clr
`ifdef STROBE_STREAM_OVF_CNT_EN
    ,
    output logic [OVF_CNT_W-1:0] ovf_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]        rptr_q, rptr_d, wptr_q, wptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic                 ovf_q, ovf_d;
    logic signed [DW-1:0] mdata_q, mdata_d, nxt_head;
    logic                 wr_req, pop, full, we, drop;

    strobe_stream_ram #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wptr_q),
        .wdata (s_data),
        .raddr (rptr_q + AW'(1)),
        .rdata (nxt_head)
    );

    // m_data is registered: load the incoming sample when it becomes the head,
    // otherwise the entry behind the current head on a pop.
    always_comb begin
        wr_req  = s_en && s_val;
        pop     = (level_q != '0) && m_rdy;
        full    = level_q == LW'(DEPTH);
        we      = wr_req && (!full || pop);
        drop    = wr_req && full && !pop;
        rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
        wptr_d  = we ? wptr_q + AW'(1) : wptr_q;
        level_d = (we && !pop) ? level_q + LW'(1) : (pop && !we) ? level_q - LW'(1) : level_q;
        ovf_d   = drop ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
        mdata_d = (we && (level_q == '0 || (pop && level_q == LW'(1)))) ? s_data :
                  (pop && level_q > LW'(1)) ? nxt_head : mdata_q;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            mdata_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            mdata_q <= mdata_d;
        end

    assign m_data = mdata_q;
    assign m_val  = level_q != '0;
    assign level  = level_q;
    assign ovf    = ovf_q;

`ifdef STROBE_STREAM_OVF_CNT_EN
    logic [OVF_CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_d = drop ? (ovf_clr ? OVF_CNT_W'(1) : (&cnt_q) ? cnt_q : cnt_q + OVF_CNT_W'(1)) :
                   ovf_clr ? '0 : cnt_q;

    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;

    assign ovf_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_strobe_stream_reader.sv
// tb_strobe_stream_reader: directed vectors against hand-computed FIFO behaviour.
module tb_strobe_stream_reader;
    import strobe_stream_pkg::*;

    localparam int DW = 16, DEPTH = 4, LW = 3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic signed [DW-1:0] s_data = '0;
    logic                 s_val = 1'b0, s_en = 1'b0, m_rdy = 1'b0, ovf_clr = 1'b0;
    logic signed [DW-1:0] m_data;
    logic                 m_val, ovf;
    logic [LW-1:0]        level;
`ifdef STROBE_STREAM_OVF_CNT_EN
    logic [OVF_CNT_W-1:0] ovf_cnt;
`endif

    int n_chk = 0, n_fail = 0;

    strobe_stream_reader #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_val   (s_val),
        .s_en    (s_en),
        .m_data  (m_data),
        .m_val   (m_val),
        .m_rdy   (m_rdy),
        .level   (level),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
`ifdef STROBE_STREAM_OVF_CNT_EN
        ,
        .ovf_cnt (ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int v);
        s_en = 1'b1; s_val = 1'b1; s_data = DW'(v);
        cyc();
        s_en = 1'b0; s_val = 1'b0;
    endtask

    function automatic fifo_status_e st(input logic [LW-1:0] l);
        return (l == 0) ? EMPTY : (l == LW'(DEPTH)) ? FULL : PARTIAL;
    endfunction

    task automatic chk_cnt(input string tag, input int exp);
`ifdef STROBE_STREAM_OVF_CNT_EN
        chk(tag, 32'(ovf_cnt), 32'(exp));
`endif
    endtask

    int fill_a [4] = '{-1, 2, -3, 4};
    int fill_b [4] = '{10, 11, 12, 13};

    initial begin
        #3;
        chk("rst_mval", m_val, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_mdata", m_data, 0);
        chk_cnt("rst_cnt", 0);
        cyc(); cyc();
        rst = 1'b1;

        m_rdy = 1'b1;
        wr(100);
        chk("t1_mval", m_val, 1);
        chk("t1_mdata", m_data, 100);
        chk("t1_level", level, 1);
        chk("t1_status", st(level), PARTIAL);
        cyc();
        chk("t1_mval_after", m_val, 0);
        chk("t1_level_after", level, 0);
        chk("t1_ovf", ovf, 0);
        chk("t1_hold", m_data, 100);

        s_val = 1'b1; s_en = 1'b0;
        for (int i = 0; i < 5; i++) begin cyc(); chk("gate_en0", m_val, 0); end
        s_val = 1'b0; s_en = 1'b1;
        for (int i = 0; i < 5; i++) begin cyc(); chk("gate_val0", level, 0); end
        s_en = 1'b0;

        m_rdy = 1'b0;
        foreach (fill_a[i]) begin
            wr(fill_a[i]);
            chk("fill_head", m_data, -1);
        end
        chk("fill_level", level, 4);
        chk("fill_status", st(level), FULL);
        chk("fill_ovf0", ovf, 0);
        wr(5);
        chk("drop_level", level, 4);
        chk("drop_ovf", ovf, 1);
        chk_cnt("drop_cnt", 1);
        m_rdy = 1'b1;
        foreach (fill_a[i]) begin
            chk("drain_data", m_data, fill_a[i]);
            cyc();
        end
        chk("drain_mval", m_val, 0);
        chk("drain_hold", m_data, 4);
        chk("drain_ovf", ovf, 1);

        ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;
        chk("clr_ovf", ovf, 0);
        chk_cnt("clr_cnt", 0);
        m_rdy = 1'b0;
        foreach (fill_b[i]) wr(fill_b[i]);
        m_rdy = 1'b1;
        wr(7);
        chk("fp_level", level, 4);
        chk("fp_ovf", ovf, 0);
        chk("fp_head", m_data, 11);
        for (int i = 1; i < 4; i++) begin
            chk("fp_data", m_data, fill_b[i]);
            cyc();
        end
        chk("fp_last", m_data, 7);
        chk("fp_last_level", level, 1);
        cyc();
        chk("fp_empty", level, 0);

        m_rdy = 1'b0;
        foreach (fill_b[i]) wr(fill_b[i]);
        ovf_clr = 1'b1;
        wr(20);
        chk("race_ovf", ovf, 1);
        chk_cnt("race_cnt", 1);
        cyc();
        ovf_clr = 1'b0;
        chk("race_clr", ovf, 0);
        chk_cnt("race_cnt_clr", 0);
        wr(21);
        chk("ar_ovf_set", ovf, 1);
        m_rdy = 1'b1; cyc(); m_rdy = 1'b0;
        chk("ar_level3", level, 3);
        #2 rst = 1'b0;
        #1;
        chk("ar_mval", m_val, 0);
        chk("ar_level", level, 0);
        chk("ar_ovf", ovf, 0);
        chk_cnt("ar_cnt", 0);
        #1 rst = 1'b1;
        cyc();
        wr(9);
        chk("ar_w_mval", m_val, 1);
        chk("ar_w_data", m_data, 9);
        chk("ar_w_level", level, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/strobe_stream_reader.md
Name: strobe_stream_reader

Overview:
- Consumer end of shift-enable strobed sample pipelines (delay lines clocked by a shift/sample enable).
- Captures a sample when both the strobe and the valid are high, buffers it in a small FIFO, and re-presents it on a valid/ready stream interface for downstream DSP.
- Detects and flags samples lost because the downstream stalled too long.

Parameters:
- DW, 16, sample width in bits (signed).
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- LW, $clog2(DEPTH)+1, width of the level output (derived; do not override).

Ports:
- clk  in  1  single clock domain.
- rst  in  1  asynchronous active-low reset.
- s_data  in  DW  signed sample from the strobed pipeline.
- s_val  in  1  sample valid.
- s_en  in  1  shift/sample strobe. A write is requested when s_en && s_val.
- m_data  out  DW  signed head-of-FIFO sample.
- m_val  out  1  m_data valid.
- m_rdy  in  1  downstream ready. A pop occurs when m_val && m_rdy.
- level  out  LW  current FIFO occupancy, 0..DEPTH.
- ovf  out  1  sticky overflow flag.
- ovf_clr  in  1  synchronous clear for ovf.

Behaviour:
- Reset (rst low, asynchronous): m_val=0, m_data=0, level=0, ovf=0, read and write pointers=0. Storage contents are don't-care.
- Write request wr_req = s_en && s_val. Samples with s_en=1, s_val=0 are ignored; samples with s_en=0 are ignored regardless of s_val.
- Latency: a sample written at edge N is visible on m_data with m_val=1 after edge N, if the FIFO was empty. There is no combinational path from s_* to m_*.
- m_data/m_val always reflect the head entry (first-word fall-through from registered storage). m_val = (level != 0).
- Pop: on m_val && m_rdy, the head advances at the clock edge and level decrements.
- Simultaneous write and pop: both happen and level is unchanged.
  - When full: the write is accepted because the pop frees a slot in the same cycle.
  - When empty: no pop is possible, since m_val=0.
- Full (level==DEPTH) with wr_req and no pop:
  - The sample is dropped; storage and pointers are unchanged.
  - ovf is set to 1 on that edge.
- ovf is cleared by ovf_clr=1 at a clock edge. If an overflow drop and ovf_clr occur on the same edge, ovf ends at 1 (set wins).
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. level is tracked separately, so full and empty are unambiguous.
- m_rdy while m_val=0 has no effect.
- Reset asserted mid-transfer empties the FIFO immediately. After release, the first wr_req edge behaves as in an empty FIFO.
- m_data holds its last value when the FIFO is empty. Only m_val qualifies it.

Optional Feature:
- Macro: STROBE_STREAM_OVF_CNT_EN.
- Defined:
  - Adds output ovf_cnt, 16 bits: a saturating count of dropped samples, saturating at 16'hFFFF.
  - Reset value is 0. ovf_clr clears it.
  - If a drop coincides with ovf_clr, ovf_cnt ends at 1.
- Undefined: no ovf_cnt port and no counter logic. ovf behaviour is identical in both builds.

Decomposition:
- Package strobe_stream_pkg:
  - function lvl_w(depth) returning $clog2(depth)+1.
  - localparam OVF_CNT_W=16.
  - typedef enum for the FIFO status encoding {EMPTY, PARTIAL, FULL}, used by the bench and assertions.
- One natural sub-module: strobe_stream_ram. It is a DEPTH x DW register array with write port (we, waddr, wdata) and asynchronous read (raddr, rdata).
- Pointer, level and overflow control stay in strobe_stream_reader.

Test Plan:
- Reset, then s_en=1, s_val=1, s_data=16'sd100 for one cycle, m_rdy=1 -> m_val=1 with m_data=100 on the next cycle; level 1 then 0; ovf=0.
- Strobe gating: s_val=1 with s_en=0 for 5 cycles, then s_en=1 with s_val=0 for 5 cycles -> m_val stays 0, level=0.
- Fill: m_rdy=0, write -1, 2, -3, 4 (DEPTH=4), then write 5 -> level=4 and ovf=1. Then m_rdy=1 reads -1, 2, -3, 4 in order; 5 never appears. With the feature macro defined, ovf_cnt=1.
- Full with simultaneous pop: level=4, wr_req and m_rdy in the same cycle with s_data=7 -> level stays 4, ovf unchanged, 7 appears as the last entry after 3 more pops.
- Clear race: drop and ovf_clr on the same edge -> ovf=1. ovf_clr alone on the next edge -> ovf=0.
- Async reset mid-stream: level=3, pull rst low between edges -> m_val=0, level=0, ovf=0 immediately. After release, write 9 -> m_data=9 on the next cycle.
